ehgu_segment_bus_arbiter: RTL and testbench

EHGU_SEGMENT_BUS_ARBITER -- requirements
Module: ehgu_segment_bus_arbiter

---
 rtl/ehgu_segment_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_ehgu_segment_bus_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ehgu_segment_bus_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters reach one of 2**SEG_WIDTH
// targets, with a local-segment address decode and an acknowledge timeout.
module ehgu_segment_bus_arbiter #(
  parameter int WIDTH      = 8,
  parameter int SEG_WIDTH  = 2,
  parameter int LOCAL_ADDR = 0,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic                       rsp_err,
  output logic [(2**SEG_WIDTH)-1:0]  tgt_sel,
  input  logic [(2**SEG_WIDTH)-1:0]  tgt_ack,
  output logic                       busy
);
  localparam int NT = 2**SEG_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT+1);
  localparam logic [WIDTH-SEG_WIDTH-1:0] LP_LOCAL = (WIDTH-SEG_WIDTH)'(LOCAL_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_win;
  logic                r_hit;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic                r_rsp_err;
  logic [NT-1:0]       r_tgt_sel;
  logic                r_busy;

  logic [WIDTH-1:0]    w_addr [NUM_REQ];
  logic                w_any;
  logic [IW-1:0]       w_win;
  logic [WIDTH-1:0]    w_waddr;
  logic                w_hit;
  logic [NT-1:0]       w_sel;
  logic                w_ack;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_addr[g] = req_addr[g*WIDTH +: WIDTH];
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_any = 1'b0;
    w_win = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_any && req_valid[IW'((int'(r_last) + k) % NUM_REQ)]) begin
        w_any = 1'b1;
        w_win = IW'((int'(r_last) + k) % NUM_REQ);
      end
    end
  end

  assign w_waddr = w_addr[w_win];
  assign w_hit   = (w_waddr[WIDTH-1:SEG_WIDTH] == LP_LOCAL);
  assign w_sel   = NT'(1) << w_waddr[SEG_WIDTH-1:0];
  // r_tgt_sel is zero on a miss, so only the selected target's ack can count.
  assign w_ack   = |(tgt_ack & r_tgt_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NUM_REQ-1);
      r_win       <= '0;
      r_hit       <= 1'b0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      r_tgt_sel   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_ACCESS;
            r_win       <= w_win;
            r_last      <= w_win;
            r_hit       <= w_hit;
            r_cnt       <= '0;
            r_req_ready <= NUM_REQ'(1) << w_win;
            r_tgt_sel   <= w_hit ? w_sel : '0;
            r_busy      <= 1'b1;
          end
        end
        S_ACCESS: begin
          // Ack is tested before the timeout so a same-cycle ack wins.
          if (!r_hit || w_ack || (r_cnt == CW'(TIMEOUT-1))) begin
            r_state     <= S_RESP;
            r_rsp_valid <= NUM_REQ'(1) << r_win;
            r_rsp_err   <= !r_hit || !w_ack;
            r_tgt_sel   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_tgt_sel <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign tgt_sel   = r_tgt_sel;
  assign busy      = r_busy;
endmodule

// File: tb/tb_ehgu_segment_bus_arbiter.sv
// Scoreboard bench: expected grants/completions (with due cycle) are queued at
// stimulus time and checked by a monitor whenever the arbiter pulses.
module tb_ehgu_segment_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic        rsp_err;
  logic [3:0]  tgt_sel;
  logic [3:0]  tgt_ack;
  logic        busy;

  ehgu_segment_bus_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .tgt_sel(tgt_sel), .tgt_ack(tgt_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int err; int due;} exp_t;
  exp_t gq[$];
  exp_t rq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input int idx, input int due);
    exp_t e;
    e.idx = idx; e.err = 0; e.due = due;
    gq.push_back(e);
  endtask

  task automatic push_r(input int idx, input int err, input int due);
    exp_t e;
    e.idx = idx; e.err = err; e.due = due;
    rq.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [7:0] a);
    req_valid[idx]       = 1'b1;
    req_addr[idx*8 +: 8] = a;
  endtask

  // Monitor: every ready/rsp pulse must match the head of its queue, on time.
  always @(negedge clk) begin
    exp_t e;
    if (req_ready != 4'b0) begin
      if (gq.size() == 0) chk("ready_unexpected", 64'(req_ready), 64'd0);
      else begin
        e = gq.pop_front();
        chk("ready_vec", 64'(req_ready), 64'd1 << e.idx);
        chk("ready_cycle", 64'(cyc), 64'(e.due));
      end
    end
    if (rsp_valid != 4'b0) begin
      if (rq.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else begin
        e = rq.pop_front();
        chk("rsp_vec", 64'(rsp_valid), 64'd1 << e.idx);
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1; req_valid = '0; req_addr = '0; tgt_ack = '0;
    tick; tick;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp",   64'(rsp_valid), 64'd0);
    chk("rst_err",   64'(rsp_err),   64'd0);
    chk("rst_sel",   64'(tgt_sel),   64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    rst = 1'b0;
    tick;

    // Hit with immediate ack; address changes after grant must not matter.
    c0 = cyc; set_req(1, 8'h02); push_g(1, c0+1); push_r(1, 0, c0+2);
    tick;
    chk("hit_sel", 64'(tgt_sel), 64'b0100);
    chk("hit_busy", 64'(busy), 64'd1);
    req_valid = '0; req_addr[8 +: 8] = 8'hFF; tgt_ack = 4'b0100;
    tick;
    chk("hit_rsp", 64'(rsp_valid), 64'b0010);
    chk("hit_rsp_sel0", 64'(tgt_sel), 64'd0);
    tgt_ack = '0;
    tick;
    chk("hit_idle_busy", 64'(busy), 64'd0);

    // Miss: one ACCESS cycle, error response; acks ignored.
    c0 = cyc; set_req(0, 8'h07); push_g(0, c0+1); push_r(0, 1, c0+2);
    tick;
    chk("miss_sel", 64'(tgt_sel), 64'd0);
    req_valid = '0; tgt_ack = 4'b1111;
    tick;
    chk("miss_rsp", 64'(rsp_valid), 64'b0001);
    chk("miss_err", 64'(rsp_err), 64'd1);
    tgt_ack = '0;
    tick;

    // Timeout without ack: requester 2 (search starts at 1).
    c0 = cyc; set_req(2, 8'h01); push_g(2, c0+1); push_r(2, 1, c0+16);
    tick;
    req_valid = '0;
    for (int k = 1; k <= 15; k++) begin
      chk("to_sel", 64'(tgt_sel), 64'b0010);
      tick;
    end
    chk("to_rsp", 64'(rsp_valid), 64'b0100);
    chk("to_sel0", 64'(tgt_sel), 64'd0);
    tick;

    // Ack in the last allowed cycle wins over the timeout.
    c0 = cyc; set_req(3, 8'h01); push_g(3, c0+1); push_r(3, 0, c0+16);
    tick;
    req_valid = '0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 15) tgt_ack = 4'b0010;
      tick;
    end
    tgt_ack = '0;
    chk("to_ack_rsp", 64'(rsp_valid), 64'b1000);
    chk("to_ack_err", 64'(rsp_err), 64'd0);
    tick;

    // Stray ack on a non-selected target is ignored.
    c0 = cyc; set_req(0, 8'h00); push_g(0, c0+1);
    tick;
    chk("stray_sel", 64'(tgt_sel), 64'b0001);
    req_valid = '0; tgt_ack = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("stray_norsp", 64'(rsp_valid), 64'd0);
    end
    tgt_ack = 4'b0001; push_r(0, 0, cyc+1);
    tick;
    tgt_ack = '0;
    chk("stray_rsp", 64'(rsp_valid), 64'b0001);
    tick;

    // Round robin after reset with all requesters held: 0,1,2,3,0.
    rst = 1'b1; tick; rst = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 4; i++) set_req(i, 8'h10 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      push_g(k % 4, c0 + 1 + 3*k);
      push_r(k % 4, 1, c0 + 2 + 3*k);
    end
    repeat (13) tick;
    req_valid = '0;
    tick; tick;
    chk("rr_idle_busy", 64'(busy), 64'd0);

    // Reset mid-ACCESS aborts; a same-edge ack must not complete it.
    c0 = cyc; set_req(2, 8'h03); push_g(2, c0+1);
    tick;
    req_valid = '0;
    chk("abort_sel", 64'(tgt_sel), 64'b1000);
    tick; tick;
    rst = 1'b1; tgt_ack = 4'b1000;
    tick;
    rst = 1'b0; tgt_ack = '0;
    chk("abort_sel0", 64'(tgt_sel), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_norsp", 64'(rsp_valid), 64'd0);
    tick; tick;
    c0 = cyc;
    for (int i = 0; i < 4; i++) set_req(i, 8'h20);
    push_g(0, c0+1); push_r(0, 1, c0+2);
    tick;
    req_valid = '0;
    tick; tick; tick;

    chk("grant_q_empty", 64'(gq.size()), 64'd0);
    chk("rsp_q_empty", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
